// File: rtl/seg_mon_pkg.sv
// Shared definitions for the seven-segment receive monitor: segment encodings,
// FSM state type and the pattern-to-BCD decoder.
package seg_mon_pkg;

  // Segment encodings, bit0 = a ... bit6 = g, active-high.
  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;

  typedef enum logic {
    WAIT_FIRST = 1'b0,
    TRACK      = 1'b1
  } mon_state_e;

  // Returns {valid, digit}; anything outside the ten digit glyphs is invalid.
  function automatic logic [4:0] seg_decode(input logic [6:0] pattern);
    logic [4:0] res;
    res = 5'b0_0000;
    case (pattern)
      SEG_0:   res = {1'b1, 4'd0};
      SEG_1:   res = {1'b1, 4'd1};
      SEG_2:   res = {1'b1, 4'd2};
      SEG_3:   res = {1'b1, 4'd3};
      SEG_4:   res = {1'b1, 4'd4};
      SEG_5:   res = {1'b1, 4'd5};
      SEG_6:   res = {1'b1, 4'd6};
      SEG_7:   res = {1'b1, 4'd7};
      SEG_8:   res = {1'b1, 4'd8};
      SEG_9:   res = {1'b1, 4'd9};
      default: res = 5'b0_0000;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/seven_segment_monitor_seg_stable_filter.sv
// Input path of the monitor: 2-flop synchronizer, stability counter and
// one-shot acceptance of each new stable segment pattern.
module seg_stable_filter #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg_in,
  output logic       accept,
  output logic [6:0] acc_pat
);

  localparam logic [CNT_W-1:0] STABLE_MAX = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] STABLE_M1  = CNT_W'(STABLE_CYCLES - 1);

  logic [6:0]       sync1_q, sync1_d;
  logic [6:0]       sync_seg_q, sync_seg_d;
  logic [6:0]       cand_q, cand_d;
  logic [6:0]       last_pat_q, last_pat_d;
  logic [CNT_W-1:0] stab_cnt_q, stab_cnt_d;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    sync1_d    = seg_in;
    sync_seg_d = sync1_q;
    cand_d     = sync_seg_q;
    last_pat_d = last_pat_q;
    stab_cnt_d = stab_cnt_q;
    accept     = 1'b0;

    if (sync_seg_q != cand_q) begin
      stab_cnt_d = '0;
    end else if (stab_cnt_q != STABLE_MAX) begin
      stab_cnt_d = stab_cnt_q + 1'b1;
    end

    // Fire only on the cycle the count reaches its limit, and only for a
    // pattern different from the last one taken, so a held glyph never repeats.
    if ((sync_seg_q == cand_q) && (stab_cnt_q == STABLE_M1) && (cand_q != last_pat_q)) begin
      accept     = 1'b1;
      last_pat_d = cand_q;
    end
  end

  assign acc_pat = cand_q;

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q    <= 7'h00;
      sync_seg_q <= 7'h00;
      cand_q     <= 7'h00;
      last_pat_q <= 7'h00;
      stab_cnt_q <= '0;
    end else begin
      sync1_q    <= sync1_d;
      sync_seg_q <= sync_seg_d;
      cand_q     <= cand_d;
      last_pat_q <= last_pat_d;
      stab_cnt_q <= stab_cnt_d;
    end
  end

endmodule

// File: rtl/seven_segment_monitor.sv
// Seven-segment loopback monitor: decodes stable glyphs and checks the 0..9
// count order. Define SEG_MON_ERRCNT_EN to build the sequence-error counter.
module seven_segment_monitor
  import seg_mon_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] segments_in,
  output logic [3:0] digit,
  output logic       digit_valid,
  output logic       invalid,
  output logic       seq_err,
  output logic       locked,
  output logic [7:0] err_count
);

  logic       accept;
  logic [6:0] acc_pat;
  logic [4:0] dec;
  logic       dec_valid;
  logic [3:0] dec_digit;
  logic [3:0] next_digit;

  mon_state_e state_q, state_d;
  logic [3:0] digit_q, digit_d;
  logic       digit_valid_q, digit_valid_d;
  logic       invalid_q, invalid_d;
  logic       seq_err_q, seq_err_d;
  logic       locked_q, locked_d;

  seg_stable_filter #(
    .STABLE_CYCLES(STABLE_CYCLES),
    .CNT_W        (CNT_W)
  ) u_filter (
    .clk    (clk),
    .rst    (rst),
    .seg_in (segments_in),
    .accept (accept),
    .acc_pat(acc_pat)
  );

  assign dec        = seg_decode(acc_pat);
  assign dec_valid  = dec[4];
  assign dec_digit  = dec[3:0];
  assign next_digit = (digit_q == 4'd9) ? 4'd0 : digit_q + 4'd1;

  always_comb begin
    state_d       = state_q;
    digit_d       = digit_q;
    locked_d      = locked_q;
    digit_valid_d = 1'b0;
    invalid_d     = 1'b0;
    seq_err_d     = 1'b0;

    if (accept) begin
      if (!dec_valid) begin
        // Digit is held across a non-digit so the next one is checked against it.
        invalid_d = 1'b1;
      end else begin
        digit_d       = dec_digit;
        digit_valid_d = 1'b1;
        case (state_q)
          WAIT_FIRST: begin
            locked_d = 1'b1;
            state_d  = TRACK;
          end
          TRACK: seq_err_d = (dec_digit != next_digit);
          default: state_d = WAIT_FIRST;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= WAIT_FIRST;
      digit_q       <= 4'd0;
      digit_valid_q <= 1'b0;
      invalid_q     <= 1'b0;
      seq_err_q     <= 1'b0;
      locked_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      digit_q       <= digit_d;
      digit_valid_q <= digit_valid_d;
      invalid_q     <= invalid_d;
      seq_err_q     <= seq_err_d;
      locked_q      <= locked_d;
    end
  end

  assign digit       = digit_q;
  assign digit_valid = digit_valid_q;
  assign invalid     = invalid_q;
  assign seq_err     = seq_err_q;
  assign locked      = locked_q;

`ifdef SEG_MON_ERRCNT_EN
  logic [7:0] err_count_q, err_count_d;

  always_comb begin
    err_count_d = err_count_q;
    if (seq_err_d && (err_count_q != 8'hFF)) begin
      err_count_d = err_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_count_q <= 8'h00;
    end else begin
      err_count_q <= err_count_d;
    end
  end

  assign err_count = err_count_q;
`else
  assign err_count = 8'h00;
`endif

endmodule

// File: tb/tb_seven_segment_monitor.sv
// Directed bench for seven_segment_monitor: exact latency, a table of held
// glyphs with expected pulse counts, glitch, invalid and reset sequences.
module tb_seven_segment_monitor;

  logic       clk;
  logic       rst;
  logic [6:0] segments_in;
  logic [3:0] digit;
  logic       digit_valid;
  logic       invalid;
  logic       seq_err;
  logic       locked;
  logic [7:0] err_count;

  int checks   = 0;
  int failures = 0;
  int exp_errs = 0;

  typedef struct {
    logic [6:0] seg;
    int         hold;
    int         n_valid;
    int         n_inv;
    int         n_seq;
    logic [3:0] digit;
  } vec_t;

  vec_t vecs[20];

  seven_segment_monitor dut (
    .clk        (clk),
    .rst        (rst),
    .segments_in(segments_in),
    .digit      (digit),
    .digit_valid(digit_valid),
    .invalid    (invalid),
    .seq_err    (seq_err),
    .locked     (locked),
    .err_count  (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] exp_err_count();
`ifdef SEG_MON_ERRCNT_EN
    return 8'(exp_errs);
`else
    return 8'h00;
`endif
  endfunction

  task automatic check_all_clear(input string tag);
    check({tag, "_digit"},       32'(digit), 32'd0);
    check({tag, "_digit_valid"}, 32'(digit_valid), 32'd0);
    check({tag, "_invalid"},     32'(invalid), 32'd0);
    check({tag, "_seq_err"},     32'(seq_err), 32'd0);
    check({tag, "_locked"},      32'(locked), 32'd0);
    check({tag, "_err_count"},   32'(err_count), 32'd0);
  endtask

  initial begin
    int nv, ni, ns;
    bit seen;

    vecs[0]  = '{7'h06, 10, 1, 0, 0, 4'd1};
    vecs[1]  = '{7'h4F,  2, 0, 0, 0, 4'd1};  // short glitch
    vecs[2]  = '{7'h06, 10, 0, 0, 0, 4'd1};
    vecs[3]  = '{7'h5B, 10, 1, 0, 0, 4'd2};
    vecs[4]  = '{7'h4F, 10, 1, 0, 0, 4'd3};
    vecs[5]  = '{7'h66, 10, 1, 0, 0, 4'd4};
    vecs[6]  = '{7'h6D, 10, 1, 0, 0, 4'd5};
    vecs[7]  = '{7'h7D, 10, 1, 0, 0, 4'd6};
    vecs[8]  = '{7'h07, 10, 1, 0, 0, 4'd7};
    vecs[9]  = '{7'h7F, 10, 1, 0, 0, 4'd8};
    vecs[10] = '{7'h6F, 10, 1, 0, 0, 4'd9};
    vecs[11] = '{7'h3F, 10, 1, 0, 0, 4'd0};  // 9 -> 0 wrap is legal
    vecs[12] = '{7'h06, 10, 1, 0, 0, 4'd1};
    vecs[13] = '{7'h66, 10, 1, 0, 1, 4'd4};  // skips 2,3
    vecs[14] = '{7'h5B, 10, 1, 0, 1, 4'd2};  // 4 -> 2
    vecs[15] = '{7'h00, 10, 0, 1, 0, 4'd2};  // blank holds digit
    vecs[16] = '{7'h4F, 10, 1, 0, 0, 4'd3};
    vecs[17] = '{7'h49, 10, 0, 1, 0, 4'd3};
    vecs[18] = '{7'h66, 10, 1, 0, 0, 4'd4};
    vecs[19] = '{7'h6D, 10, 1, 0, 0, 4'd5};

    rst         = 1'b0;
    segments_in = 7'h00;
    repeat (3) step();
    check_all_clear("reset");
    rst = 1'b1;
    repeat (4) step();
    check("blank_after_reset_no_pulse", 32'({digit_valid, invalid}), 32'd0);

    // Exact latency: change before edge 0, pulse registered at edge 6.
    segments_in = 7'h3F;
    for (int e = 0; e <= 6; e++) begin
      step();
      if (e < 6) check($sformatf("latency_edge%0d_quiet", e), 32'(digit_valid), 32'd0);
    end
    check("first_valid", 32'(digit_valid), 32'd1);
    check("first_digit", 32'(digit), 32'd0);
    check("first_locked", 32'(locked), 32'd1);
    check("first_seq_err", 32'(seq_err), 32'd0);
    nv = 0;
    repeat (10) begin
      step();
      if (digit_valid) nv++;
    end
    check("held_no_retrigger", 32'(nv), 32'd0);

    for (int v = 0; v < 20; v++) begin
      segments_in = vecs[v].seg;
      nv = 0; ni = 0; ns = 0;
      for (int c = 0; c < vecs[v].hold; c++) begin
        step();
        if (digit_valid) nv++;
        if (invalid) ni++;
        if (seq_err) ns++;
        check($sformatf("v%0d_excl", v), 32'(digit_valid & invalid), 32'd0);
        check($sformatf("v%0d_seq_without_valid", v), 32'(seq_err & ~digit_valid), 32'd0);
      end
      exp_errs += vecs[v].n_seq;
      check($sformatf("v%0d_valid_pulses", v), 32'(nv), 32'(vecs[v].n_valid));
      check($sformatf("v%0d_invalid_pulses", v), 32'(ni), 32'(vecs[v].n_inv));
      check($sformatf("v%0d_seq_err_pulses", v), 32'(ns), 32'(vecs[v].n_seq));
      check($sformatf("v%0d_digit", v), 32'(digit), 32'(vecs[v].digit));
      check($sformatf("v%0d_err_count", v), 32'(err_count), 32'(exp_err_count()));
    end

    // Asynchronous reset mid-stream at digit 5.
    rst = 1'b0;
    #1;
    check_all_clear("midreset_async");
    repeat (2) step();
    check_all_clear("midreset_held");
    exp_errs = 0;
    rst = 1'b1;
    step();

    // Non-digit in WAIT_FIRST: invalid pulse, still unlocked.
    segments_in = 7'h49;
    nv = 0; ni = 0;
    repeat (10) begin
      step();
      if (digit_valid) nv++;
      if (invalid) ni++;
    end
    check("wait_first_invalid_pulses", 32'(ni), 32'd1);
    check("wait_first_no_valid", 32'(nv), 32'd0);
    check("wait_first_unlocked", 32'(locked), 32'd0);

    // First digit after reset is never a sequence error.
    segments_in = 7'h7F;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      step();
      if (digit_valid) seen = 1'b1;
    end
    check("post_reset_valid_seen", 32'(seen), 32'd1);
    check("post_reset_digit", 32'(digit), 32'd8);
    check("post_reset_seq_err", 32'(seq_err), 32'd0);
    check("post_reset_locked", 32'(locked), 32'd1);
    check("post_reset_err_count", 32'(err_count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
